// File: rtl/pic_pkg.sv
// Shared definitions for the 8259-style PIC: sequencer states and the bit
// positions of the ICW1/ICW4/OCW3 fields within the CPU data byte.
package pic_pkg;

  typedef enum logic [2:0] {
    IDLE,
    W_ICW2,
    W_ICW3,
    W_ICW4,
    READY
  } pic_state_t;

  localparam int IC4       = 0;
  localparam int SNGL      = 1;
  localparam int ADI       = 2;
  localparam int LTIM      = 3;
  localparam int ICW1_FLAG = 4;

  localparam int UPM  = 0;
  localparam int AEOI = 1;
  localparam int MS   = 2;
  localparam int BUF  = 3;
  localparam int SFNM = 4;

  localparam int OCW3_FLAG = 3;

endpackage

// File: rtl/pic_init_sequencer_if.sv
// CPU write port of the PIC: one-cycle write strobe with address bit A0 and data.
interface pic_init_sequencer_if;
  logic       wr;
  logic       a_0;
  logic [7:0] din;

  modport master (output wr, a_0, din);
  modport slave  (input  wr, a_0, din);
endinterface

// File: rtl/pic_init_sequencer.sv
// Walks the ICW1..ICW4 programming sequence, holds the programmed fields, and
// once ready takes OCW1 mask writes and forwards OCW2/OCW3 to the control logic.
module pic_init_sequencer
  import pic_pkg::*;
#(
  parameter int              IR_N      = 8,
  parameter int              CAS_ID_W  = 3,
  parameter logic [IR_N-1:0] IMR_RESET = '1
) (
  input  logic                    clk,
  input  logic                    reset,
  pic_init_sequencer_if.slave     bus,
  input  logic                    sp_en_n,
  output logic                    ltim,
  output logic                    adi,
  output logic                    sngl,
  output logic                    ic4,
  output logic [4:0]              vec_base,
  output logic [7:0]              icw3,
  output logic [CAS_ID_W-1:0]     slave_id,
  output logic                    upm,
  output logic                    aeoi,
  output logic                    buf_mode,  // ICW4 BUF bit; 'buf' is a reserved gate keyword
  output logic                    ms,
  output logic                    sfnm,
  output logic                    is_master,
  output logic [IR_N-1:0]         imr,
  output logic                    init_done,
  output logic                    ocw_wr,
  output logic [7:0]              ocw_data,
  output logic                    seq_err
);

  pic_state_t state, state_nx;
  logic ld_icw1, ld_icw2, ld_icw3, ld_icw4, ld_imr, ocw_nx, err_nx;

  // NOTE: every signal gets a default before the decode so no path leaves one
  // unassigned; otherwise synthesis infers a latch.
  always_comb begin
    state_nx = state;
    ld_icw1  = 1'b0;
    ld_icw2  = 1'b0;
    ld_icw3  = 1'b0;
    ld_icw4  = 1'b0;
    ld_imr   = 1'b0;
    ocw_nx   = 1'b0;
    err_nx   = 1'b0;
    if (bus.wr) begin
      if (!bus.a_0 && bus.din[ICW1_FLAG]) begin
        ld_icw1  = 1'b1;
        state_nx = W_ICW2;
      end else if (!bus.a_0) begin
        if (state == READY) ocw_nx = 1'b1;
        else                err_nx = 1'b1;
      end else begin
        unique case (state)
          IDLE: err_nx = 1'b1;
          W_ICW2: begin
            ld_icw2 = 1'b1;
            if (!sngl)    state_nx = W_ICW3;
            else if (ic4) state_nx = W_ICW4;
            else          state_nx = READY;
          end
          W_ICW3: begin
            ld_icw3  = 1'b1;
            state_nx = ic4 ? W_ICW4 : READY;
          end
          W_ICW4: begin
            ld_icw4  = 1'b1;
            state_nx = READY;
          end
          READY:   ld_imr = 1'b1;
          default: state_nx = IDLE;
        endcase
      end
    end
  end

  // NOTE: clocked state uses non-blocking assignments so every register samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      {ltim, adi, sngl, ic4}            <= '0;
      vec_base                          <= '0;
      icw3                              <= '0;
      {sfnm, buf_mode, ms, aeoi, upm}   <= '0;
      imr                               <= IMR_RESET;
      ocw_wr                            <= 1'b0;
      ocw_data                          <= '0;
      seq_err                           <= 1'b0;
    end else begin
      ocw_wr  <= ocw_nx;
      seq_err <= err_nx;
      if (ocw_nx) ocw_data <= bus.din;
      if (ld_icw1) begin
        ltim                            <= bus.din[LTIM];
        adi                             <= bus.din[ADI];
        sngl                            <= bus.din[SNGL];
        ic4                             <= bus.din[IC4];
        imr                             <= '0;
        icw3                            <= '0;
        {sfnm, buf_mode, ms, aeoi, upm} <= '0;
      end
      if (ld_icw2) vec_base <= bus.din[7:3];
      if (ld_icw3) icw3     <= bus.din;
      if (ld_icw4) begin
        upm      <= bus.din[UPM];
        aeoi     <= bus.din[AEOI];
        ms       <= bus.din[MS];
        buf_mode <= bus.din[BUF];
        sfnm     <= bus.din[SFNM];
      end
      if (ld_imr) imr <= bus.din[IR_N-1:0];
    end
  end

  assign init_done = (state == READY);
  assign slave_id  = icw3[CAS_ID_W-1:0];
  // Single mode is always master; buffered mode takes the role from ICW4,
  // otherwise the SP/EN pin decides.
  assign is_master = sngl ? 1'b1 : (buf_mode ? ms : sp_en_n);

endmodule

// File: tb/tb_pic_init_sequencer.sv
// Self-checking bench for pic_init_sequencer: directed vector table, a few
// hand-written sequences, then random traffic against a queue-based model.
module tb_pic_init_sequencer;
  import pic_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic       sp_en_n;
  logic       ltim, adi, sngl, ic4, upm, aeoi, buf_mode, ms, sfnm;
  logic       is_master, init_done, ocw_wr, seq_err;
  logic [4:0] vec_base;
  logic [7:0] icw3, imr, ocw_data;
  logic [2:0] slave_id;

  pic_init_sequencer_if bus ();

  pic_init_sequencer dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .sp_en_n   (sp_en_n),
    .ltim      (ltim),
    .adi       (adi),
    .sngl      (sngl),
    .ic4       (ic4),
    .vec_base  (vec_base),
    .icw3      (icw3),
    .slave_id  (slave_id),
    .upm       (upm),
    .aeoi      (aeoi),
    .buf_mode  (buf_mode),
    .ms        (ms),
    .sfnm      (sfnm),
    .is_master (is_master),
    .imr       (imr),
    .init_done (init_done),
    .ocw_wr    (ocw_wr),
    .ocw_data  (ocw_data),
    .seq_err   (seq_err)
  );

  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
    end
  endtask

  // Reference model: fields plus a queue of the ICWs still owed after ICW1.
  typedef struct {
    bit         ltim, adi, sngl, ic4;
    logic [4:0] vb;
    logic [7:0] icw3;
    bit         upm, aeoi, bufm, ms, sfnm;
    logic [7:0] imr;
    bit         started;
    bit         ocw;
    logic [7:0] od;
    bit         err;
  } model_t;

  model_t m;
  int     pending[$];
  bit     cur_sp;

  task automatic model_apply(input bit r, input bit w, input bit a, input logic [7:0] d);
    int which;
    m.ocw = 1'b0;
    m.err = 1'b0;
    if (r) begin
      m = '{default: 0};
      m.imr = 8'hFF;
      pending.delete();
    end else if (w) begin
      if (!a && d[4]) begin
        {m.ltim, m.adi, m.sngl, m.ic4} = d[3:0];
        m.imr  = 8'h00;
        m.icw3 = 8'h00;
        {m.sfnm, m.bufm, m.ms, m.aeoi, m.upm} = 5'b0;
        m.started = 1'b1;
        pending.delete();
        pending.push_back(2);
        if (!m.sngl) pending.push_back(3);
        if (m.ic4)   pending.push_back(4);
      end else if (!a) begin
        if (m.started && pending.size() == 0) begin
          m.ocw = 1'b1;
          m.od  = d;
        end else begin
          m.err = 1'b1;
        end
      end else if (!m.started) begin
        m.err = 1'b1;
      end else if (pending.size() != 0) begin
        which = pending.pop_front();
        case (which)
          2:       m.vb   = d[7:3];
          3:       m.icw3 = d;
          default: {m.sfnm, m.bufm, m.ms, m.aeoi, m.upm} = d[4:0];
        endcase
      end else begin
        m.imr = d;
      end
    end
  endtask

  // One clock cycle: drive at a falling edge, observe at the next falling edge.
  task automatic step(input bit r, input bit w, input bit a, input logic [7:0] d, input bit s);
    reset   = r;
    bus.wr  = w;
    bus.a_0 = a;
    bus.din = d;
    sp_en_n = s;
    cur_sp  = s;
    @(negedge clk);
    model_apply(r, w, a, d);
  endtask

  task automatic check_all(input string tag);
    bit exp_master;
    exp_master = m.sngl ? 1'b1 : (m.bufm ? m.ms : cur_sp);
    check({tag, ".icw1"},   {ltim, adi, sngl, ic4}, {m.ltim, m.adi, m.sngl, m.ic4});
    check({tag, ".vec"},    vec_base, m.vb);
    check({tag, ".icw3"},   icw3, m.icw3);
    check({tag, ".sid"},    slave_id, m.icw3[2:0]);
    check({tag, ".icw4"},   {sfnm, buf_mode, ms, aeoi, upm}, {m.sfnm, m.bufm, m.ms, m.aeoi, m.upm});
    check({tag, ".imr"},    imr, m.imr);
    check({tag, ".init"},   init_done, m.started && pending.size() == 0);
    check({tag, ".ocw_wr"}, ocw_wr, m.ocw);
    check({tag, ".err"},    seq_err, m.err);
    check({tag, ".master"}, is_master, exp_master);
    if (m.ocw)
      check({tag, m.od[OCW3_FLAG] ? ".ocw3_data" : ".ocw2_data"}, ocw_data, m.od);
  endtask

  typedef struct {
    bit         rst, wr, a0;
    logic [7:0] d;
    bit         sp;
    logic [3:0] e_icw1;
    logic [4:0] e_vec;
    logic [7:0] e_icw3;
    logic [4:0] e_icw4;
    logic [7:0] e_imr;
    bit         e_init, e_ocw;
    logic [7:0] e_od;
    bit         e_err, e_master;
    logic [2:0] e_sid;
  } vec_t;

  vec_t tbl[$];

  initial begin
    // rst wr a0 din sp | icw1 vec icw3 icw4 imr init ocw od err master sid
    tbl.push_back('{1,0,0,8'h00,1, 4'h0,5'h00,8'h00,5'h00,8'hFF,0,0,8'h00,0,1,3'd0}); // reset
    tbl.push_back('{0,1,0,8'h1A,1, 4'hA,5'h00,8'h00,5'h00,8'h00,0,0,8'h00,0,1,3'd0}); // single, no ICW4
    tbl.push_back('{0,1,1,8'h48,1, 4'hA,5'h09,8'h00,5'h00,8'h00,1,0,8'h00,0,1,3'd0});
    tbl.push_back('{0,0,0,8'h00,1, 4'hA,5'h09,8'h00,5'h00,8'h00,1,0,8'h00,0,1,3'd0});
    tbl.push_back('{0,1,1,8'hF3,1, 4'hA,5'h09,8'h00,5'h00,8'hF3,1,0,8'h00,0,1,3'd0}); // OCW1
    tbl.push_back('{0,1,0,8'h20,1, 4'hA,5'h09,8'h00,5'h00,8'hF3,1,1,8'h20,0,1,3'd0}); // OCW2
    tbl.push_back('{0,1,0,8'h0B,1, 4'hA,5'h09,8'h00,5'h00,8'hF3,1,1,8'h0B,0,1,3'd0}); // OCW3
    tbl.push_back('{0,0,0,8'h00,1, 4'hA,5'h09,8'h00,5'h00,8'hF3,1,0,8'h00,0,1,3'd0});
    tbl.push_back('{0,1,0,8'h11,1, 4'h1,5'h09,8'h00,5'h00,8'h00,0,0,8'h00,0,1,3'd0}); // ICW1 in READY
    tbl.push_back('{0,1,1,8'h20,1, 4'h1,5'h04,8'h00,5'h00,8'h00,0,0,8'h00,0,1,3'd0});
    tbl.push_back('{0,1,0,8'h20,1, 4'h1,5'h04,8'h00,5'h00,8'h00,0,0,8'h00,1,1,3'd0}); // OCW2 in W_ICW3
    tbl.push_back('{0,1,1,8'h04,1, 4'h1,5'h04,8'h04,5'h00,8'h00,0,0,8'h00,0,1,3'd4});
    tbl.push_back('{0,1,1,8'h1D,0, 4'h1,5'h04,8'h04,5'h1D,8'h00,1,0,8'h00,0,1,3'd4}); // buffered master
    tbl.push_back('{0,0,0,8'h00,1, 4'h1,5'h04,8'h04,5'h1D,8'h00,1,0,8'h00,0,1,3'd4});
    tbl.push_back('{0,1,0,8'h11,0, 4'h1,5'h04,8'h00,5'h00,8'h00,0,0,8'h00,0,0,3'd0}); // slave via pin
    tbl.push_back('{0,1,1,8'h70,0, 4'h1,5'h0E,8'h00,5'h00,8'h00,0,0,8'h00,0,0,3'd0});
    tbl.push_back('{0,1,1,8'h02,0, 4'h1,5'h0E,8'h02,5'h00,8'h00,0,0,8'h00,0,0,3'd2});
    tbl.push_back('{0,1,1,8'h01,0, 4'h1,5'h0E,8'h02,5'h01,8'h00,1,0,8'h00,0,0,3'd2});
    tbl.push_back('{0,1,0,8'h11,1, 4'h1,5'h0E,8'h00,5'h00,8'h00,0,0,8'h00,0,1,3'd0}); // restart
    tbl.push_back('{0,1,1,8'h20,1, 4'h1,5'h04,8'h00,5'h00,8'h00,0,0,8'h00,0,1,3'd0});
    tbl.push_back('{1,1,1,8'h55,1, 4'h0,5'h00,8'h00,5'h00,8'hFF,0,0,8'h00,0,1,3'd0}); // reset + wr in W_ICW3
    tbl.push_back('{0,0,0,8'h00,1, 4'h0,5'h00,8'h00,5'h00,8'hFF,0,0,8'h00,0,1,3'd0});
    tbl.push_back('{0,1,1,8'h33,1, 4'h0,5'h00,8'h00,5'h00,8'hFF,0,0,8'h00,1,1,3'd0}); // A0=1 in IDLE
    tbl.push_back('{0,0,0,8'h00,1, 4'h0,5'h00,8'h00,5'h00,8'hFF,0,0,8'h00,0,1,3'd0});
  end

  initial begin
    string t;
    reset = 1'b1; bus.wr = 1'b0; bus.a_0 = 1'b0; bus.din = 8'h00; sp_en_n = 1'b1;
    m = '{default: 0};
    m.imr = 8'hFF;
    @(negedge clk);

    foreach (tbl[i]) begin
      step(tbl[i].rst, tbl[i].wr, tbl[i].a0, tbl[i].d, tbl[i].sp);
      t = $sformatf("tbl%0d", i);
      check({t, ".icw1"},   {ltim, adi, sngl, ic4}, tbl[i].e_icw1);
      check({t, ".vec"},    vec_base, tbl[i].e_vec);
      check({t, ".icw3"},   icw3, tbl[i].e_icw3);
      check({t, ".icw4"},   {sfnm, buf_mode, ms, aeoi, upm}, tbl[i].e_icw4);
      check({t, ".imr"},    imr, tbl[i].e_imr);
      check({t, ".init"},   init_done, tbl[i].e_init);
      check({t, ".ocw_wr"}, ocw_wr, tbl[i].e_ocw);
      check({t, ".err"},    seq_err, tbl[i].e_err);
      check({t, ".master"}, is_master, tbl[i].e_master);
      check({t, ".sid"},    slave_id, tbl[i].e_sid);
      if (tbl[i].e_ocw) check({t, ".ocw_data"}, ocw_data, tbl[i].e_od);
    end

    // Single mode with ICW4, back-to-back writes, then illegal write in W_ICW2.
    step(1, 0, 0, 8'h00, 1); check_all("seqA.rst");
    step(0, 1, 0, 8'h13, 0); check_all("seqA.icw1");
    step(0, 1, 0, 8'h0C, 0); check_all("seqA.ocw_in_icw2");
    step(0, 1, 1, 8'hC8, 0); check_all("seqA.icw2");
    step(0, 1, 1, 8'h02, 0); check_all("seqA.icw4");
    step(0, 1, 1, 8'h5A, 0); check_all("seqA.ocw1");
    step(0, 0, 1, 8'hFF, 0); check_all("seqA.hold");
    // Reset coincident with an ICW1 discards it.
    step(1, 1, 0, 8'h1F, 1); check_all("seqB.rst_icw1");
    step(0, 0, 0, 8'h00, 1); check_all("seqB.idle");

    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 49) == 0, $urandom_range(0, 9) < 8, 1'($urandom_range(0, 1)),
           8'($urandom), 1'($urandom_range(0, 1)));
      check_all($sformatf("rnd%0d", i));
      check("rnd.excl", ocw_wr & seq_err, 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
